// File: rtl/lsu_wb_stage.sv
// Load/store-to-writeback pipeline register with a one-entry skid buffer.
// Load data is extracted and extended on capture, so the writeback stage sees final GPR values.
module lsu_wb_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_in_valid,
  output logic              ls_in_ready,
  input  logic [63:0]       ls_in_PC,
  input  logic [63:0]       ls_in_next_PC,
  input  logic [31:0]       ls_in_inst,
  input  logic              ls_in_trap_valid,
  input  logic              ls_in_mret_valid,
  input  logic              ls_in_sret_valid,
  input  logic              ls_in_dret_valid,
  input  logic [63:0]       ls_in_trap_cause,
  input  logic [63:0]       ls_in_trap_tval,
  input  logic              ls_in_csr_wen,
  input  logic              ls_in_csr_ren,
  input  logic [11:0]       ls_in_csr_addr,
  input  logic [4:0]        ls_in_rd,
  input  logic              ls_in_dest_wen,
  input  logic [DATA_W-1:0] ls_in_data,
  input  logic              ls_in_load_en,
  input  logic [1:0]        ls_in_load_size,
  input  logic              ls_in_load_unsigned,
  input  logic [2:0]        ls_in_load_offset,
  input  logic              WB_LS_ls_ready,
  input  logic              WB_LS_flush_flag,
  output logic              LS_WB_reg_ls_valid,
  output logic [63:0]       LS_WB_reg_PC,
  output logic [63:0]       LS_WB_reg_next_PC,
  output logic [31:0]       LS_WB_reg_inst,
  output logic              LS_WB_reg_trap_valid,
  output logic              LS_WB_reg_mret_valid,
  output logic              LS_WB_reg_sret_valid,
  output logic              LS_WB_reg_dret_valid,
  output logic [63:0]       LS_WB_reg_trap_cause,
  output logic [63:0]       LS_WB_reg_trap_tval,
  output logic              LS_WB_reg_csr_wen,
  output logic              LS_WB_reg_csr_ren,
  output logic [11:0]       LS_WB_reg_csr_addr,
  output logic [4:0]        LS_WB_reg_rd,
  output logic              LS_WB_reg_dest_wen,
  output logic [DATA_W-1:0] LS_WB_reg_data
);

  typedef struct packed {
    logic [63:0]       pc;
    logic [63:0]       next_pc;
    logic [31:0]       inst;
    logic              trap_valid;
    logic              mret_valid;
    logic              sret_valid;
    logic              dret_valid;
    logic [63:0]       trap_cause;
    logic [63:0]       trap_tval;
    logic              csr_wen;
    logic              csr_ren;
    logic [11:0]       csr_addr;
    logic [4:0]        rd;
    logic              dest_wen;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;
  entry_t in_entry;
  logic   accept;
  logic   main_free;

  // Lane select ignores offset bits below the access size (misalignment is handled upstream).
  function automatic logic [63:0] format_load(input logic [63:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [2:0]  offset);
    logic [63:0] sh;
    logic [63:0] res;
    sh  = raw;
    res = raw;
    case (size)
      2'd0: begin
        sh  = raw >> {offset, 3'b000};
        res = uns ? {56'b0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
      end
      2'd1: begin
        sh  = raw >> {offset[2:1], 4'b0000};
        res = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      end
      2'd2: begin
        sh  = raw >> {offset[2], 5'b00000};
        res = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    in_entry            = '0;
    in_entry.pc         = ls_in_PC;
    in_entry.next_pc    = ls_in_next_PC;
    in_entry.inst       = ls_in_inst;
    in_entry.trap_valid = ls_in_trap_valid;
    in_entry.mret_valid = ls_in_mret_valid;
    in_entry.sret_valid = ls_in_sret_valid;
    in_entry.dret_valid = ls_in_dret_valid;
    in_entry.trap_cause = ls_in_trap_cause;
    in_entry.trap_tval  = ls_in_trap_tval;
    // A trapping instruction must not retire any architectural write.
    in_entry.csr_wen    = ls_in_csr_wen & ~ls_in_trap_valid;
    in_entry.csr_ren    = ls_in_csr_ren & ~ls_in_trap_valid;
    in_entry.csr_addr   = ls_in_csr_addr;
    in_entry.rd         = ls_in_rd;
    in_entry.dest_wen   = ls_in_dest_wen & ~ls_in_trap_valid;
    in_entry.data       = ls_in_load_en ?
                          format_load(ls_in_data, ls_in_load_size, ls_in_load_unsigned,
                                      ls_in_load_offset) : ls_in_data;
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    accept       = ls_in_valid && ready_q && !WB_LS_flush_flag;
    main_free    = !main_valid_q || WB_LS_ls_ready;

    if (WB_LS_flush_flag) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // Skid is older than anything on the input, so it always goes first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end

    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign ls_in_ready          = ready_q;
  assign LS_WB_reg_ls_valid   = main_valid_q;
  assign LS_WB_reg_PC         = main_q.pc;
  assign LS_WB_reg_next_PC    = main_q.next_pc;
  assign LS_WB_reg_inst       = main_q.inst;
  assign LS_WB_reg_trap_valid = main_q.trap_valid;
  assign LS_WB_reg_mret_valid = main_q.mret_valid;
  assign LS_WB_reg_sret_valid = main_q.sret_valid;
  assign LS_WB_reg_dret_valid = main_q.dret_valid;
  assign LS_WB_reg_trap_cause = main_q.trap_cause;
  assign LS_WB_reg_trap_tval  = main_q.trap_tval;
  assign LS_WB_reg_csr_wen    = main_q.csr_wen;
  assign LS_WB_reg_csr_ren    = main_q.csr_ren;
  assign LS_WB_reg_csr_addr   = main_q.csr_addr;
  assign LS_WB_reg_rd         = main_q.rd;
  assign LS_WB_reg_dest_wen   = main_q.dest_wen;
  assign LS_WB_reg_data       = main_q.data;

endmodule

// File: doc/lsu_wb_stage.md
LSU_WB_STAGE -- requirements
Module: lsu_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning GPR/CSR data width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port ls_in_valid, input, 1, LSU result valid.
REQ-005 SHALL have port ls_in_ready, output, 1, stage can accept a result.
REQ-006 SHALL have ports ls_in_PC / ls_in_next_PC, input, 64 each, instruction PC and successor PC.
REQ-007 SHALL have port ls_in_inst, input, 32, instruction word.
REQ-008 SHALL have ports ls_in_trap_valid / ls_in_mret_valid / ls_in_sret_valid / ls_in_dret_valid, input, 1 each, trap and return markers.
REQ-009 SHALL have ports ls_in_trap_cause / ls_in_trap_tval, input, 64 each, trap cause and value.
REQ-010 SHALL have ports ls_in_csr_wen / ls_in_csr_ren, input, 1 each, and ls_in_csr_addr, input, 12, CSR access.
REQ-011 SHALL have ports ls_in_rd, input, 5, and ls_in_dest_wen, input, 1, GPR destination.
REQ-012 SHALL have port ls_in_data, input, 64, ALU result or raw 64-bit aligned memory doubleword.
REQ-013 SHALL have ports ls_in_load_en, input, 1; ls_in_load_size, input, 2 (0 B, 1 H, 2 W, 3 D); ls_in_load_unsigned, input, 1; ls_in_load_offset, input, 3 (addr[2:0]).
REQ-014 SHALL have port WB_LS_ls_ready, input, 1, write-back accepts the entry.
REQ-015 SHALL have port WB_LS_flush_flag, input, 1, pipeline flush from write-back.
REQ-016 SHALL have port LS_WB_reg_ls_valid, output, 1, entry valid toward write-back.
REQ-017 SHALL have outputs LS_WB_reg_{PC,next_PC,inst,trap_valid,mret_valid,sret_valid,dret_valid,trap_cause,trap_tval,csr_wen,csr_ren,csr_addr,rd,dest_wen,data}, widths as the matching ls_in_* inputs, all driven directly from flops.

Function
REQ-018 SHALL hold two entries: main (drives LS_WB_reg_*) and skid; each has a valid bit.
REQ-019 SHALL drive ls_in_ready = !skid_valid, from a flop, no combinational path from WB_LS_ls_ready.
REQ-020 SHALL accept an entry when ls_in_valid && ls_in_ready && !WB_LS_flush_flag.
REQ-021 SHALL, when main empty or main drained this cycle (main_valid && WB_LS_ls_ready), load main from skid if skid valid, else from the accepted input; latency input-to-LS_WB_reg_ls_valid = 1 cycle.
REQ-022 SHALL, when main is valid and not drained, place an accepted input into skid; skid never overwritten while valid.
REQ-023 SHALL preserve program order: skid always drains into main before any newer input.
REQ-024 SHALL, on WB_LS_flush_flag=1, clear main_valid and skid_valid next edge and discard same-cycle input; flush dominates accept and drain.
REQ-025 SHALL format data at capture when load_en=1: B uses byte offset[2:0], H offset[2:1], W offset[2], D whole word; low misaligned offset bits ignored; sign-extend to 64 unless load_unsigned; D ignores load_unsigned.
REQ-026 SHALL pass ls_in_data unchanged when load_en=0.
REQ-027 SHALL store dest_wen, csr_wen and csr_ren forced 0 when trap_valid=1.
REQ-028 SHALL hold all LS_WB_reg_* payload stable while LS_WB_reg_ls_valid=1 and WB_LS_ls_ready=0.
REQ-029 SHALL not update payload flops of an invalid entry beyond capture (no requirement on payload when valid=0).

Reset
REQ-030 SHALL, while rst=1, force main_valid=0, skid_valid=0, ls_in_ready=1 and all LS_WB_reg_* outputs to 0, asynchronously.
REQ-031 SHALL, on rst asserted mid-transfer, drop both entries; first accept possible on first edge after rst deasserts.

Verification
REQ-032 SHALL verify: lb, data=0x0000_0000_0080_0000, offset=2, unsigned=0 -> LS_WB_reg_data=0xFFFF_FFFF_FFFF_FF80 next cycle; lbu -> 0x80.
REQ-033 SHALL verify: lw, data=0x8000_0001_0000_0002, offset=4 -> 0xFFFF_FFFF_8000_0001; lwu -> 0x0000_0000_8000_0001.
REQ-034 SHALL verify: WB_LS_ls_ready=0, three back-to-back inputs A,B,C -> A in main, B in skid, ls_in_ready=0, C held; ready=1 -> outputs A, B, C in order, no loss.
REQ-035 SHALL verify: flush with main and skid valid plus input valid -> next cycle LS_WB_reg_ls_valid=0, ls_in_ready=1, input dropped.
REQ-036 SHALL verify: trap_valid=1, dest_wen=1, csr_wen=1 -> LS_WB_reg_dest_wen=0, LS_WB_reg_csr_wen=0, trap_cause passed.
REQ-037 SHALL verify: rst pulse while both entries valid -> all outputs 0 immediately, ls_in_ready=1.
